// File: rtl/slv_burst_scheduler.sv
// ----------------------------------------------------------------------------
// slv_burst_scheduler
//
// Purpose: arbitrates two burst sources (slv0/slv1) onto one datapath.
// A round-robin decision in IDLE picks the owner and latches its mode.
// Beats are then accepted from that owner until BURST_LEN beats have
// been taken or the owner drops its request. The scheduler then waits
// for the downstream engine to report completion.
//
// Optional feature (macro SCHED_TIMEOUT_EN): a watchdog limits the time
// spent waiting for completion to TIMEOUT_CYC cycles. If the watchdog
// expires, it raises the sticky sched_err flag and returns to IDLE.
// Without the macro the wait is unbounded and sched_err is tied to 0.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   slv0_req / slv1_req      source has a burst pending
//   slv0_mode / slv1_mode    mode requested by each source
//   beat_valid               a beat is presented by the granted source
//   fifo_full                output FIFO cannot accept data
//   mstr0_cmplt              downstream processing finished the burst
//   slv0_gnt / slv1_gnt      beat acceptance grant per source
//   data_source              owner of the datapath (0 = slv0, 1 = slv1)
//   slvx_mode                mode latched for the active burst
//   stall                    grant withheld because fifo_full is high
//   burst_done               one-cycle pulse after completion is seen
//   sched_err                sticky watchdog error
//   dbg_state                FSM state (0 IDLE, 1 GRANT, 2 WAIT_CMPLT)
//   dbg_beat_cnt             beats accepted in the current/last burst
//
// Handshake: a beat is transferred on a rising edge where the owner's gnt
// and beat_valid are both high. The gnt signal is high only in GRANT with
// fifo_full low. A beat_valid with gnt low is not a transfer and is ignored.
// ----------------------------------------------------------------------------
module slv_burst_scheduler #(
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       slv0_req,
    input  logic       slv1_req,
    input  logic [1:0] slv0_mode,
    input  logic [1:0] slv1_mode,
    input  logic       beat_valid,
    input  logic       fifo_full,
    input  logic       mstr0_cmplt,
    output logic       slv0_gnt,
    output logic       slv1_gnt,
    output logic       data_source,
    output logic [1:0] slvx_mode,
    output logic       stall,
    output logic       burst_done,
    output logic       sched_err,
    output logic [1:0] dbg_state,
    output logic [8:0] dbg_beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_WAIT_CMPLT = 2'd2
    } state_t;

    // The beat that reaches BURST_LEN is the one accepted while the count
    // still reads BURST_LEN-1.
    localparam logic [8:0] LP_LAST_BEAT = 9'(BURST_LEN - 1);

    // Reject illegal configurations at elaboration time.
    if (BURST_LEN < 2 || BURST_LEN > 256 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_params
        $error("slv_burst_scheduler: BURST_LEN or TIMEOUT_CYC out of range");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_data_source;
    logic [1:0] r_mode;
    logic [8:0] r_beat_cnt;
    logic       r_last_src;
    logic       r_burst_done;

    logic       w_winner;
    logic       w_own_req;
    logic       w_accept;
    logic       w_pick;
    logic       w_release;
    logic       w_done_nxt;
    logic       w_gnt;
    logic       w_stall;
    logic       w_timeout;

    // On a tie the source that did not own the previous burst wins; a lone
    // requester wins regardless of history.
    assign w_winner  = (slv0_req && slv1_req) ? ~r_last_src : slv1_req;
    assign w_own_req = r_data_source ? slv1_req : slv0_req;
    assign w_accept  = (r_state == ST_GRANT) && !fifo_full && beat_valid;

`ifdef SCHED_TIMEOUT_EN
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_wait_cnt;
    logic       r_sched_err;

    // Counter reads k during the (k+1)-th WAIT_CMPLT cycle, so the
    // watchdog fires after exactly TIMEOUT_CYC cycles of waiting.
    assign w_timeout = (r_state == ST_WAIT_CMPLT) && !mstr0_cmplt &&
                       (r_wait_cnt == LP_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= 8'd0;
            r_sched_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_CMPLT) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
            if (w_timeout) begin
                r_sched_err <= 1'b1;
            end
        end
    end

    assign sched_err = r_sched_err;
`else
    assign w_timeout = 1'b0;
    assign sched_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_data_source <= 1'b0;
            r_mode        <= 2'd0;
            r_beat_cnt    <= 9'd0;
            r_last_src    <= 1'b1;
            r_burst_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_done <= w_done_nxt;
            if (w_pick) begin
                r_data_source <= w_winner;
                r_mode        <= w_winner ? slv1_mode : slv0_mode;
                r_beat_cnt    <= 9'd0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            if (w_release) begin
                r_last_src <= r_data_source;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pick      = 1'b0;
        w_release   = 1'b0;
        w_done_nxt  = 1'b0;
        w_gnt       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (slv0_req || slv1_req) begin
                    w_pick      = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_gnt   = !fifo_full;
                w_stall = fifo_full;
                // A beat accepted in the same cycle the request drops is
                // still counted (the counter update is independent).
                if ((w_accept && r_beat_cnt == LP_LAST_BEAT) || !w_own_req) begin
                    w_state_nxt = ST_WAIT_CMPLT;
                end
            end
            ST_WAIT_CMPLT: begin
                if (mstr0_cmplt) begin
                    w_done_nxt  = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign slv0_gnt     = w_gnt && !r_data_source;
    assign slv1_gnt     = w_gnt && r_data_source;
    assign stall        = w_stall;
    assign data_source  = r_data_source;
    assign slvx_mode    = r_mode;
    assign burst_done   = r_burst_done;
    assign dbg_state    = r_state;
    assign dbg_beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_slv_burst_scheduler.sv
// ----------------------------------------------------------------------------
// tb_slv_burst_scheduler
//
// Directed bench for slv_burst_scheduler with BURST_LEN = 4 and
// TIMEOUT_CYC = 10. A transaction-level model tracks who owns the datapath,
// whether beats are still being taken, and how many beats were accepted.
// It predicts every output on each falling clock edge. The completed-burst
// beat counts go through an expected queue that is checked on burst_done.
// ----------------------------------------------------------------------------
module tb_slv_burst_scheduler;

    localparam int BL = 4;
    localparam int TO = 10;

    logic       clk;
    logic       rst_n;
    logic       slv0_req;
    logic       slv1_req;
    logic [1:0] slv0_mode;
    logic [1:0] slv1_mode;
    logic       beat_valid;
    logic       fifo_full;
    logic       mstr0_cmplt;
    logic       slv0_gnt;
    logic       slv1_gnt;
    logic       data_source;
    logic [1:0] slvx_mode;
    logic       stall;
    logic       burst_done;
    logic       sched_err;
    logic [1:0] dbg_state;
    logic [8:0] dbg_beat_cnt;

    slv_burst_scheduler #(
        .BURST_LEN   (BL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slv0_req     (slv0_req),
        .slv1_req     (slv1_req),
        .slv0_mode    (slv0_mode),
        .slv1_mode    (slv1_mode),
        .beat_valid   (beat_valid),
        .fifo_full    (fifo_full),
        .mstr0_cmplt  (mstr0_cmplt),
        .slv0_gnt     (slv0_gnt),
        .slv1_gnt     (slv1_gnt),
        .data_source  (data_source),
        .slvx_mode    (slvx_mode),
        .stall        (stall),
        .burst_done   (burst_done),
        .sched_err    (sched_err),
        .dbg_state    (dbg_state),
        .dbg_beat_cnt (dbg_beat_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, got running required finished");
        $fatal(1);
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_stall  = 0;
    int n_acc    = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       m_busy;
    logic       m_taking;
    logic       m_src;
    logic       m_last;
    logic       m_done;
    logic       m_err;
    logic [1:0] m_mode;
    int         m_beats;
    int         m_wait;

    task automatic model_reset();
        m_busy   = 1'b0;
        m_taking = 1'b0;
        m_src    = 1'b0;
        m_last   = 1'b1;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_mode   = 2'd0;
        m_beats  = 0;
        m_wait   = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_done = 1'b0;
                if (!m_busy) begin
                    if (slv0_req || slv1_req) begin
                        m_src    = (slv0_req && slv1_req) ? !m_last : slv1_req;
                        m_mode   = m_src ? slv1_mode : slv0_mode;
                        m_beats  = 0;
                        m_busy   = 1'b1;
                        m_taking = 1'b1;
                    end
                end else if (m_taking) begin
                    if (beat_valid && !fifo_full) m_beats++;
                    if (m_beats == BL || !(m_src ? slv1_req : slv0_req)) begin
                        m_taking = 1'b0;
                        m_wait   = 0;
                    end
                end else begin
                    if (mstr0_cmplt) begin
                        m_done = 1'b1;
                        m_last = m_src;
                        m_busy = 1'b0;
                        exp_q.push_back(32'(m_beats));
                    end
`ifdef SCHED_TIMEOUT_EN
                    else begin
                        m_wait++;
                        if (m_wait == TO) begin
                            m_err  = 1'b1;
                            m_last = m_src;
                            m_busy = 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic eg;
        eg = m_busy && m_taking && !fifo_full;
        check("slv0_gnt", 32'(slv0_gnt), 32'(eg && !m_src));
        check("slv1_gnt", 32'(slv1_gnt), 32'(eg && m_src));
        check("stall", 32'(stall), 32'(m_busy && m_taking && fifo_full));
        check("data_source", 32'(data_source), 32'(m_src));
        check("slvx_mode", 32'(slvx_mode), 32'(m_mode));
        check("burst_done", 32'(burst_done), 32'(m_done));
        check("sched_err", 32'(sched_err), 32'(m_err));
        check("beat_cnt", 32'(dbg_beat_cnt), 32'(m_beats));
        if (burst_done) begin
            if (exp_q.size() == 0) begin
                check("burst_done_queue", 32'(exp_q.size()), 32'd1);
            end else begin
                check("burst_beats", 32'(dbg_beat_cnt), exp_q.pop_front());
            end
        end
        n_done  += int'(burst_done);
        n_stall += int'(stall);
        n_acc   += int'(beat_valid && (slv0_gnt || slv1_gnt));
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int k;
        k = 0;
        while (dbg_state !== s && k < 60) begin
            step(1);
            k++;
        end
        check(name, 32'(dbg_state), 32'(s));
    endtask

    task automatic pulse_cmplt();
        mstr0_cmplt = 1'b1;
        step(1);
        mstr0_cmplt = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int a0;
        int d0;
        int s0;
        rst_n       = 1'b0;
        slv0_req    = 1'b0;
        slv1_req    = 1'b0;
        slv0_mode   = 2'd0;
        slv1_mode   = 2'd0;
        beat_valid  = 1'b0;
        fifo_full   = 1'b0;
        mstr0_cmplt = 1'b0;
        step(3);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_gnt0", 32'(slv0_gnt), 32'd0);
        check("rst_src", 32'(data_source), 32'd0);
        rst_n = 1'b1;

        // Both sources request from reset: slv0 wins the first tie.
        slv0_mode  = 2'd1;
        slv1_mode  = 2'd2;
        slv0_req   = 1'b1;
        slv1_req   = 1'b1;
        beat_valid = 1'b1;
        a0 = n_acc;
        d0 = n_done;
        wait_state(2'd1, "s1_grant");
        check("s1_src", 32'(data_source), 32'd0);
        check("s1_mode", 32'(slvx_mode), 32'd1);
        wait_state(2'd2, "s1_wait");
        check("s1_beats", 32'(n_acc - a0), 32'd4);
        slv0_req = 1'b0;
        step(1);
        pulse_cmplt();
        wait_state(2'd1, "s1_next_grant");
        check("s1_done", 32'(n_done - d0), 32'd1);
        check("s1_next_src", 32'(data_source), 32'd1);
        check("s1_next_mode", 32'(slvx_mode), 32'd2);

        // slv1 burst: completion ignored in GRANT, FIFO stalls for 3 cycles.
        a0 = n_acc;
        d0 = n_done;
        mstr0_cmplt = 1'b1;
        step(1);
        mstr0_cmplt = 1'b0;
        fifo_full   = 1'b1;
        s0 = n_stall;
        step(3);
        check("s2_frozen_cnt", 32'(dbg_beat_cnt), 32'd1);
        check("s2_still_grant", 32'(dbg_state), 32'd1);
        fifo_full = 1'b0;
        wait_state(2'd2, "s2_wait");
        check("s2_stall_cycles", 32'(n_stall - s0), 32'd3);
        check("s2_beats", 32'(n_acc - a0), 32'd4);
        check("s2_no_early_done", 32'(n_done - d0), 32'd0);
        slv1_req   = 1'b0;
        beat_valid = 1'b0;
        step(1);
        pulse_cmplt();
        step(1);
        check("s2_done", 32'(n_done - d0), 32'd1);

        // Completion pulse while idle does nothing.
        d0 = n_done;
        pulse_cmplt();
        step(2);
        check("s4_idle_state", 32'(dbg_state), 32'd0);
        check("s4_idle_no_done", 32'(n_done - d0), 32'd0);

        // slv1 alone, request falls together with the 2nd beat.
        slv1_mode  = 2'd3;
        slv1_req   = 1'b1;
        beat_valid = 1'b1;
        d0 = n_done;
        wait_state(2'd1, "s3_grant");
        step(1);
        slv1_req = 1'b0;
        step(1);
        beat_valid = 1'b0;
        check("s3_wait", 32'(dbg_state), 32'd2);
        check("s3_cnt", 32'(dbg_beat_cnt), 32'd2);
        step(2);
        pulse_cmplt();
        step(1);
        check("s3_done", 32'(n_done - d0), 32'd1);
        check("s3_cnt_after", 32'(dbg_beat_cnt), 32'd2);
        check("s3_mode", 32'(slvx_mode), 32'd3);

        // Watchdog behaviour: slv0 wins (slv1 owned last), slv1 keeps asking.
        slv0_req   = 1'b1;
        slv1_req   = 1'b1;
        beat_valid = 1'b1;
        wait_state(2'd1, "s5_grant");
        check("s5_src", 32'(data_source), 32'd0);
        wait_state(2'd2, "s5_wait");
        slv0_req = 1'b0;
        d0 = n_done;
`ifdef SCHED_TIMEOUT_EN
        step(TO - 1);
        check("s5_err_before", 32'(sched_err), 32'd0);
        check("s5_still_wait", 32'(dbg_state), 32'd2);
        step(1);
        check("s5_err_set", 32'(sched_err), 32'd1);
        check("s5_idle", 32'(dbg_state), 32'd0);
`else
        step(20);
        check("s5_wait_forever", 32'(dbg_state), 32'd2);
        check("s5_err_tied", 32'(sched_err), 32'd0);
        pulse_cmplt();
`endif
        wait_state(2'd1, "s5_next_grant");
        check("s5_next_src", 32'(data_source), 32'd1);
        wait_state(2'd2, "s5_next_wait");
        slv1_req = 1'b0;
        pulse_cmplt();
        step(1);

        // Reset in GRANT at beat 2, then slv0 wins the first tie again.
        slv0_mode  = 2'd2;
        slv0_req   = 1'b1;
        slv1_req   = 1'b1;
        beat_valid = 1'b1;
        wait_state(2'd1, "s6_grant");
        step(2);
        check("s6_cnt_before", 32'(dbg_beat_cnt), 32'd2);
        d0 = n_done;
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_gnt0", 32'(slv0_gnt), 32'd0);
        check("s6_rst_stall", 32'(stall), 32'd0);
        check("s6_rst_mode", 32'(slvx_mode), 32'd0);
        check("s6_rst_cnt", 32'(dbg_beat_cnt), 32'd0);
        check("s6_rst_state", 32'(dbg_state), 32'd0);
        check("s6_rst_err", 32'(sched_err), 32'd0);
        step(2);
        rst_n = 1'b1;
        wait_state(2'd1, "s6_regrant");
        check("s6_first_tie", 32'(data_source), 32'd0);
        check("s6_no_done", 32'(n_done - d0), 32'd0);
        slv0_req = 1'b0;
        slv1_req = 1'b0;
        beat_valid = 1'b0;
        step(3);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
